zrle_blk_ctrl: RTL and testbench

//  Block sequencer for one zrle encoder instance: accepts a per-block element count, forwards upstream

---
 rtl/zrle_blk_ctrl_if.sv | 49 ++++
 rtl/zrle_blk_ctrl.sv | 133 +++++++++++++
 tb/tb_zrle_blk_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zrle_blk_ctrl_if.sv
// Handshake bundle between the block sequencer, its upstream flag source and
// the attached zrle encoder.
//   slave  : zrle_blk_ctrl side (receives start/flags, drives zrle controls)
//   master : environment side (drives start/flags, models zrle and downstream)
// Optional macro ZRLE_BLK_CTRL_PERF_EN adds cyc_cnt_o and stall_cnt_o.
interface zrle_blk_ctrl_if #(
  parameter int unsigned BLK_LEN_W = 16,
  parameter int unsigned WCNT_W    = 16
);
  logic                 start_i;
  logic [BLK_LEN_W-1:0] blk_len_i;
  logic                 busy_o;
  logic                 done_o;
  logic [WCNT_W-1:0]    word_cnt_o;
  logic                 nz_i;
  logic                 vld_i;
  logic                 rdy_o;
  logic                 zrle_is_one_o;
  logic                 zrle_flush_o;
  logic                 zrle_vld_o;
  logic                 zrle_rdy_i;
  logic                 zrle_idle_i;
  logic                 zrle_dvld_i;
  logic                 zrle_drdy_i;
`ifdef ZRLE_BLK_CTRL_PERF_EN
  logic [31:0]          cyc_cnt_o;
  logic [31:0]          stall_cnt_o;
`endif

  modport slave (
    input  start_i, blk_len_i, nz_i, vld_i,
    input  zrle_rdy_i, zrle_idle_i, zrle_dvld_i, zrle_drdy_i,
    output busy_o, done_o, word_cnt_o, rdy_o,
    output zrle_is_one_o, zrle_flush_o, zrle_vld_o
`ifdef ZRLE_BLK_CTRL_PERF_EN
    , output cyc_cnt_o, stall_cnt_o
`endif
  );

  modport master (
    output start_i, blk_len_i, nz_i, vld_i,
    output zrle_rdy_i, zrle_idle_i, zrle_dvld_i, zrle_drdy_i,
    input  busy_o, done_o, word_cnt_o, rdy_o,
    input  zrle_is_one_o, zrle_flush_o, zrle_vld_o
`ifdef ZRLE_BLK_CTRL_PERF_EN
    , input cyc_cnt_o, stall_cnt_o
`endif
  );
endinterface

// File: rtl/zrle_blk_ctrl.sv
// Block sequencer for one zrle encoder instance. Accepts a block length,
// forwards upstream nonzero flags into zrle, raises flush on the last element,
// waits for zrle to drain to idle, then pulses done_o. Counts encoded words
// leaving zrle (saturating) and holds the count until the next start.
//
// Ports
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (zrle shares it)
//   bus    : zrle_blk_ctrl_if.slave
//            start_i/blk_len_i in, busy_o/done_o/word_cnt_o out,
//            nz_i/vld_i in, rdy_o out (upstream element handshake),
//            zrle_is_one_o/zrle_flush_o/zrle_vld_o out, zrle_rdy_i/zrle_idle_i in,
//            zrle_dvld_i/zrle_drdy_i in (zrle output handshake, snooped)
// Optional macro ZRLE_BLK_CTRL_PERF_EN adds cyc_cnt_o (start..done inclusive)
// and stall_cnt_o (RUN cycles with vld_i high and zrle not ready).
//
// state | meaning
// IDLE  | waiting for start_i; upstream blocked
// RUN   | passing elements into zrle; flush on element len_q
// DRAIN | flush taken, waiting for zrle_idle_i
// DONE  | one-cycle done_o pulse, back to IDLE
module zrle_blk_ctrl #(
  parameter int unsigned BLK_LEN_W = 16,
  parameter int unsigned WCNT_W    = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  zrle_blk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [BLK_LEN_W-1:0] len_q;
  logic [BLK_LEN_W-1:0] elem_cnt_q;
  logic [WCNT_W-1:0]    word_cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic in_run;
  logic last_elem;
  logic elem_acc;
  logic word_hs;

  assign in_run    = (state_q == RUN);
  assign last_elem = (elem_cnt_q == len_q);
  assign elem_acc  = in_run & bus.vld_i & bus.zrle_rdy_i;
  // Words can still leave zrle after the flush handshake, so DRAIN counts too.
  assign word_hs   = ((state_q == RUN) || (state_q == DRAIN)) & bus.zrle_dvld_i & bus.zrle_drdy_i;

  assign bus.rdy_o         = in_run & bus.zrle_rdy_i;
  assign bus.zrle_vld_o    = in_run & bus.vld_i;
  assign bus.zrle_is_one_o = in_run & bus.nz_i;
  assign bus.zrle_flush_o  = in_run & last_elem;

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.word_cnt_o = word_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      elem_cnt_q <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (word_hs && (word_cnt_q != '1)) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            len_q      <= bus.blk_len_i;
            elem_cnt_q <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (elem_acc) begin
            elem_cnt_q <= elem_cnt_q + BLK_LEN_W'(1);
            if (last_elem) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Only entered on the flush edge, so idle seen here is post-flush idle.
          if (bus.zrle_idle_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ZRLE_BLK_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] stall_cnt_q;

  assign bus.cyc_cnt_o   = cyc_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.start_i) begin
      // The accepting cycle itself is the first counted cycle.
      cyc_cnt_q   <= 32'd1;
      stall_cnt_q <= '0;
    end else begin
      if ((state_q != IDLE) && (cyc_cnt_q != '1)) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      if (in_run && bus.vld_i && !bus.zrle_rdy_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_zrle_blk_ctrl.sv
// Bench for zrle_blk_ctrl with a small zrle stand-in: flags are packed MSB-first
// into 8-bit words, a word leaves when full or on flush, and zrle is idle once
// its output register and flush state are clear.
module tb_zrle_blk_ctrl;
  localparam int BLK_LEN_W = 16;
  localparam int WCNT_W    = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  zrle_blk_ctrl_if #(.BLK_LEN_W(BLK_LEN_W), .WCNT_W(WCNT_W)) bus ();
  zrle_blk_ctrl #(.BLK_LEN_W(BLK_LEN_W), .WCNT_W(WCNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // zrle stand-in
  logic [7:0] m_buf, m_odata, m_nb;
  logic [2:0] m_n;
  logic       m_ovld, m_fl, m_acc;
  assign m_acc           = bus.zrle_vld_o && bus.zrle_rdy_i;
  assign m_nb            = m_buf | (8'(bus.zrle_is_one_o) << (3'd7 - m_n));
  assign bus.zrle_rdy_i  = !m_fl && (!m_ovld || bus.zrle_drdy_i);
  assign bus.zrle_idle_i = !m_ovld && !m_fl && (m_n == 3'd0);
  assign bus.zrle_dvld_i = m_ovld;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_buf <= '0; m_n <= '0; m_ovld <= 1'b0; m_fl <= 1'b0; m_odata <= '0;
    end else begin
      if (m_ovld && bus.zrle_drdy_i) m_ovld <= 1'b0;
      if (m_fl && !m_ovld) m_fl <= 1'b0;
      if (m_acc) begin
        if ((m_n == 3'd7) || bus.zrle_flush_o) begin
          m_ovld  <= 1'b1;
          m_odata <= m_nb;
          m_buf   <= '0;
          m_n     <= '0;
          m_fl    <= bus.zrle_flush_o;
        end else begin
          m_buf <= m_nb;
          m_n   <= m_n + 3'd1;
        end
      end
    end
  end

  typedef struct {
    logic [15:0] len;
    logic [15:0] pat;
    int          stall;
    int          exp_wc;
    bit          glitch;
    bit          bubble;
  } vec_t;

  vec_t       vecs[6];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_done  = 0;
  int         mon_idx = 0;
  int         flush_cyc = 0;
  logic [15:0] exp_len = '0;
  logic [15:0] exp_pat = '0;
  logic [7:0]  exp_q[$];
  int          r_i, r_g;
  logic        r_hs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_i && bus.done_o) n_done = n_done + 1;
  end

  // element monitor: flush only on the last element, flags passed through intact
  always @(negedge clk_i) begin
    if (!rst_i && bus.zrle_vld_o && bus.zrle_rdy_i) begin
      if (mon_idx > int'(exp_len)) begin
        chk("extra_elem", 32'(mon_idx), 32'(exp_len));
      end else begin
        chk("flush", 32'(bus.zrle_flush_o), 32'(mon_idx == int'(exp_len)));
        chk("is_one", 32'(bus.zrle_is_one_o), 32'(exp_pat[mon_idx]));
        if (bus.zrle_flush_o) flush_cyc = cyc;
      end
      mon_idx = mon_idx + 1;
    end
  end

  // word scoreboard
  always @(negedge clk_i) begin
    if (!rst_i && bus.zrle_dvld_i && bus.zrle_drdy_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word_extra: got %02h, no word expected", m_odata);
      end else begin
        chk("word", 32'(m_odata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic stall_ctl(input int n);
    int g = 0;
    do begin
      @(posedge clk_i); #1;
      g++;
    end while (!bus.zrle_dvld_i && g < 500);
    chk("stall_arm", 32'(bus.zrle_dvld_i), 32'd1);
    bus.zrle_drdy_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1 bus.zrle_drdy_i = 1'b1;
  endtask

  task automatic run_blk(input vec_t v);
    int         i, g, nw, done0, start_cyc, done_cyc;
    logic       hs;
    logic [7:0] w;
    nw = (int'(v.len) + 8) / 8;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int b = 0; b < 8; b++) begin
        if (k * 8 + b <= int'(v.len)) w[7-b] = v.pat[k*8+b];
      end
      exp_q.push_back(w);
    end
    exp_len = v.len;
    exp_pat = v.pat;
    mon_idx = 0;
    done0   = n_done;

    @(posedge clk_i); #1;
    bus.start_i   = 1'b1;
    bus.blk_len_i = v.len;
    start_cyc     = cyc;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    chk("busy_start", 32'(bus.busy_o), 32'd1);

    fork
      begin
        i = 0;
        g = 0;
        while (i <= int'(v.len) && g < 500) begin
          bus.vld_i = !(v.bubble && (g % 3 == 1));
          bus.nz_i  = v.pat[i];
          if (v.glitch && i == 2) begin
            bus.start_i   = 1'b1;
            bus.blk_len_i = 16'd7;
          end
          @(negedge clk_i);
          hs = bus.vld_i && bus.rdy_o;
          chk("rdy_track", 32'(bus.rdy_o), 32'(bus.zrle_rdy_i));
          @(posedge clk_i); #1;
          bus.start_i = 1'b0;
          if (hs) i++;
          g++;
        end
        bus.vld_i = 1'b0;
        chk("feed_count", 32'(i), 32'(v.len) + 32'd1);
      end
      begin
        if (v.stall > 0) stall_ctl(v.stall);
      end
    join

    g = 0;
    do begin
      @(negedge clk_i);
      g++;
    end while (!bus.done_o && g < 200);
    chk("done_seen", 32'(bus.done_o), 32'd1);
    done_cyc = cyc;
    chk("busy_in_done", 32'(bus.busy_o), 32'd1);
    chk("latency_ge2", 32'((done_cyc - flush_cyc) >= 2), 32'd1);
    chk("word_cnt", 32'(bus.word_cnt_o), 32'(v.exp_wc));
    if (v.glitch) begin
      bus.start_i   = 1'b1;
      bus.blk_len_i = 16'd5;
    end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    chk("done_pulse", 32'(bus.done_o), 32'd0);
    chk("busy_after", 32'(bus.busy_o), 32'd0);
    @(negedge clk_i);
    chk("idle_stays", 32'(bus.busy_o), 32'd0);
    chk("word_cnt_hold", 32'(bus.word_cnt_o), 32'(v.exp_wc));
    chk("done_once", 32'(n_done - done0), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("elem_count", 32'(mon_idx), 32'(v.len) + 32'd1);
`ifdef ZRLE_BLK_CTRL_PERF_EN
    chk("stall_cnt", bus.stall_cnt_o, 32'(v.stall));
    chk("cyc_cnt", bus.cyc_cnt_o, 32'(done_cyc - start_cyc + 1));
`endif
  endtask

  initial begin
    rst_i           = 1'b1;
    bus.start_i     = 1'b0;
    bus.blk_len_i   = '0;
    bus.nz_i        = 1'b0;
    bus.vld_i       = 1'b0;
    bus.zrle_drdy_i = 1'b1;

    vecs[0] = '{len: 16'd3,  pat: 16'h000F, stall: 0,  exp_wc: 1, glitch: 1'b0, bubble: 1'b0};
    vecs[1] = '{len: 16'd15, pat: 16'hFFFF, stall: 0,  exp_wc: 2, glitch: 1'b0, bubble: 1'b0};
    vecs[2] = '{len: 16'd0,  pat: 16'h0000, stall: 0,  exp_wc: 1, glitch: 1'b0, bubble: 1'b0};
    vecs[3] = '{len: 16'd15, pat: 16'hFFFF, stall: 20, exp_wc: 2, glitch: 1'b0, bubble: 1'b0};
    vecs[4] = '{len: 16'd9,  pat: 16'h0155, stall: 0,  exp_wc: 2, glitch: 1'b0, bubble: 1'b1};
    vecs[5] = '{len: 16'd3,  pat: 16'h000F, stall: 0,  exp_wc: 1, glitch: 1'b1, bubble: 1'b0};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy",   32'(bus.busy_o),       32'd0);
    chk("rst_done",   32'(bus.done_o),       32'd0);
    chk("rst_wcnt",   32'(bus.word_cnt_o),   32'd0);
    chk("rst_rdy",    32'(bus.rdy_o),        32'd0);
    chk("rst_zvld",   32'(bus.zrle_vld_o),   32'd0);
    chk("rst_zflush", 32'(bus.zrle_flush_o), 32'd0);
`ifdef ZRLE_BLK_CTRL_PERF_EN
    chk("rst_cyc",   bus.cyc_cnt_o,   32'd0);
    chk("rst_stall", bus.stall_cnt_o, 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int v = 0; v < 6; v++) run_blk(vecs[v]);

    // reset in the middle of RUN, after one word has already left zrle
    exp_len = 16'd15;
    exp_pat = 16'hFFFF;
    mon_idx = 0;
    exp_q.push_back(8'hFF);
    @(posedge clk_i); #1;
    bus.start_i   = 1'b1;
    bus.blk_len_i = 16'd15;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    r_i = 0;
    r_g = 0;
    while (r_i < 10 && r_g < 100) begin
      bus.vld_i = 1'b1;
      bus.nz_i  = 1'b1;
      @(negedge clk_i);
      r_hs = bus.vld_i && bus.rdy_o;
      @(posedge clk_i); #1;
      if (r_hs) r_i++;
      r_g++;
    end
    @(negedge clk_i);
    chk("wcnt_pre_rst", 32'(bus.word_cnt_o), 32'd1);
    chk("busy_pre_rst", 32'(bus.busy_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mid_rst_busy",   32'(bus.busy_o),       32'd0);
    chk("mid_rst_done",   32'(bus.done_o),       32'd0);
    chk("mid_rst_wcnt",   32'(bus.word_cnt_o),   32'd0);
    chk("mid_rst_rdy",    32'(bus.rdy_o),        32'd0);
    chk("mid_rst_zvld",   32'(bus.zrle_vld_o),   32'd0);
    chk("mid_rst_zflush", 32'(bus.zrle_flush_o), 32'd0);
    chk("mid_rst_sb",     32'(exp_q.size()),     32'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    bus.vld_i = 1'b0;
    rst_i     = 1'b0;

    run_blk(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
